// File: rtl/ula_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ula_pkg
// Description : Shared opcode map, FSM state encoding and opcode helpers for
//               the sequential logic/shift ALU.
// Revision    : 1.0 - initial release
// ============================================================================
package ula_pkg;

  // Full 5-bit opcode map: shifts/rotates in 01xxx, logic functions in 1xxxx
  typedef enum logic [4:0] {
    OP_SLL  = 5'b01000,
    OP_SRA  = 5'b01001,
    OP_SRL  = 5'b01010,
    OP_ROL  = 5'b01011,
    OP_ROR  = 5'b01100,
    OP_ZERO = 5'b10000,
    OP_AND  = 5'b10001,
    OP_NAB  = 5'b10010,
    OP_B    = 5'b10011,
    OP_ANB  = 5'b10100,
    OP_A    = 5'b10101,
    OP_XOR  = 5'b10110,
    OP_OR   = 5'b10111,
    OP_NOR  = 5'b11000,
    OP_XNOR = 5'b11001,
    OP_NA   = 5'b11010,
    OP_NAOB = 5'b11011,
    OP_NB   = 5'b11100,
    OP_AONB = 5'b11101,
    OP_NAND = 5'b11110,
    OP_ONE  = 5'b11111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // True for the five shift/rotate encodings
  function automatic logic is_shift(input logic [4:0] op);
    return (op >= OP_SLL) && (op <= OP_ROR);
  endfunction

  // Pass-through B and constant-one keep the previous Z and S
  function automatic logic updates_zs(input logic [4:0] op);
    return !((op == OP_B) || (op == OP_ONE));
  endfunction

  // Constant-zero refreshes Z only, so S is also held for it
  function automatic logic updates_s(input logic [4:0] op);
    return updates_zs(op) && (op != OP_ZERO);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ula_lo_logic.sv
`default_nettype none
// ============================================================================
// Module      : ula_lo_logic
// Description : Combinational 16-function bitwise logic unit (opcodes 1xxxx).
//               op_valid flags that the opcode belongs to the logic group.
// Revision    : 1.0 - initial release
// ============================================================================
module ula_lo_logic
  import ula_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       op,
  output logic [WIDTH-1:0] resu,
  output logic             op_valid
);

  // Decode the logic function; anything outside 1xxxx yields zero
  always_comb begin
    resu     = '0;
    op_valid = op[4];
    case (op)
      OP_ZERO: resu = '0;
      OP_AND:  resu = a & b;
      OP_NAB:  resu = ~a & b;
      OP_B:    resu = b;
      OP_ANB:  resu = a & ~b;
      OP_A:    resu = a;
      OP_XOR:  resu = a ^ b;
      OP_OR:   resu = a | b;
      OP_NOR:  resu = ~a & ~b;
      OP_XNOR: resu = ~(a ^ b);
      OP_NA:   resu = ~a;
      OP_NAOB: resu = ~a | b;
      OP_NB:   resu = ~b;
      OP_AONB: resu = a | ~b;
      OP_NAND: resu = ~a | ~b;
      OP_ONE:  resu = '1;
      default: resu = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ula_lo_seq.sv
`default_nettype none
// ============================================================================
// Module      : ula_lo_seq
// Description : Handshaked logic/shift ALU with registered result and
//               persistent O/C/S/Z flags. Shifts/rotates iterate one bit per
//               clock unless ULA_LO_SEQ_BARREL_EN selects a one-cycle barrel.
// Revision    : 1.0 - initial release
// ============================================================================
module ula_lo_seq
  import ula_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] resu,
  output logic             o,
  output logic             c,
  output logic             s,
  output logic             z
);

  localparam int SHW = $clog2(WIDTH);
  localparam int OPW = (WIDTH < 5) ? WIDTH : 5;

  // One-bit shift/rotate; MSB of the return value is the bit shifted out
  function automatic logic [WIDTH:0] shift_step(input logic [4:0] sop,
                                                input logic [WIDTH-1:0] x);
    logic [WIDTH:0] r;
    r = {1'b0, x};
    case (sop)
      OP_SLL:  r = {x[WIDTH-1], x[WIDTH-2:0], 1'b0};
      OP_SRA:  r = {x[0], x[WIDTH-1], x[WIDTH-1:1]};
      OP_SRL:  r = {x[0], 1'b0, x[WIDTH-1:1]};
      OP_ROL:  r = {x[WIDTH-1], x[WIDTH-2:0], x[WIDTH-1]};
      OP_ROR:  r = {x[0], x[0], x[WIDTH-1:1]};
      default: r = {1'b0, x};
    endcase
    return r;
  endfunction

  state_e           r_state;
  state_e           w_state_nxt;
  logic [WIDTH-1:0] r_work;
  logic [SHW-1:0]   r_cnt;
  logic [4:0]       r_op;
  logic             r_amsb;

  logic [SHW-1:0]   w_n;
  logic             w_accept;
  logic             w_go_shift;
  logic             w_last;
  logic [WIDTH:0]   w_step;
  logic [WIDTH-1:0] w_logic_res;
  logic             w_logic_valid;
  logic [WIDTH-1:0] w_op_ext;
  logic [WIDTH-1:0] w_imm_res;
  logic             w_imm_c;
  logic             w_imm_o;

  assign w_n       = b[SHW-1:0];
  assign in_ready  = (r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready);
  assign out_valid = (r_state == ST_DONE);
  assign w_accept  = in_valid && in_ready;
  assign w_last    = (r_cnt == SHW'(1));
  assign w_step    = shift_step(r_op, r_work);

  ula_lo_logic #(
    .WIDTH (WIDTH)
  ) u_logic (
    .a        (a),
    .b        (b),
    .op       (op),
    .resu     (w_logic_res),
    .op_valid (w_logic_valid)
  );

`ifdef ULA_LO_SEQ_BARREL_EN
  // Unrolled chain of single steps so results match the iterative path exactly
  function automatic logic [WIDTH:0] barrel(input logic [4:0] sop,
                                            input logic [WIDTH-1:0] x,
                                            input logic [SHW-1:0] n);
    logic [WIDTH:0] r;
    r = {1'b0, x};
    for (int i = 0; i < WIDTH - 1; i++) begin
      if (SHW'(i) < n) r = shift_step(sop, r[WIDTH-1:0]);
    end
    return r;
  endfunction

  logic [WIDTH:0] w_barrel;
  assign w_barrel   = barrel(op, a, w_n);
  assign w_go_shift = 1'b0;
`else
  assign w_go_shift = is_shift(op) && (w_n != '0);
`endif

  // Undefined opcodes return the opcode itself, zero-extended
  always_comb begin
    w_op_ext          = '0;
    w_op_ext[OPW-1:0] = op[OPW-1:0];
  end

  // Single-cycle result and C/O for everything that skips the SHIFT state
  always_comb begin
    w_imm_res = w_op_ext;
    w_imm_c   = c;
    w_imm_o   = o;
    if (w_logic_valid) begin
      w_imm_res = w_logic_res;
    end else if (is_shift(op)) begin
`ifdef ULA_LO_SEQ_BARREL_EN
      w_imm_res = w_barrel[WIDTH-1:0];
      if (w_n != '0) w_imm_c = w_barrel[WIDTH];
      w_imm_o   = (op == OP_SLL) && (w_barrel[WIDTH-1] != a[WIDTH-1]);
`else
      w_imm_res = a;
      w_imm_o   = 1'b0;
`endif
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state: accept from IDLE or back-to-back from DONE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_nxt = w_go_shift ? ST_SHIFT : ST_DONE;
      end
      ST_SHIFT: begin
        if (w_last) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (w_accept)       w_state_nxt = w_go_shift ? ST_SHIFT : ST_DONE;
        else if (out_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: load on accept, step while shifting, latch result and flags on DONE entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_work <= '0;
      r_cnt  <= '0;
      r_op   <= '0;
      r_amsb <= 1'b0;
      resu   <= '0;
      o      <= 1'b0;
      c      <= 1'b0;
      s      <= 1'b0;
      z      <= 1'b0;
    end else if (w_accept) begin
      r_work <= a;
      r_cnt  <= w_n;
      r_op   <= op;
      r_amsb <= a[WIDTH-1];
      if (!w_go_shift) begin
        resu <= w_imm_res;
        c    <= w_imm_c;
        o    <= w_imm_o;
        if (updates_zs(op)) z <= (w_imm_res == '0);
        if (updates_s(op))  s <= w_imm_res[WIDTH-1];
      end
    end else if (r_state == ST_SHIFT) begin
      r_work <= w_step[WIDTH-1:0];
      r_cnt  <= r_cnt - SHW'(1);
      if (w_last) begin
        resu <= w_step[WIDTH-1:0];
        c    <= w_step[WIDTH];
        o    <= (r_op == OP_SLL) && (w_step[WIDTH-1] != r_amsb);
        z    <= (w_step[WIDTH-1:0] == '0);
        s    <= w_step[WIDTH-1];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ula_lo_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_ula_lo_seq
// Description : Directed-vector bench with a scoreboard queue and an
//               independent output monitor for ula_lo_seq (WIDTH=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ula_lo_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic [4:0] op = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] resu;
  logic       o, c, s, z;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [7:0] resu;
    logic       o, c, s, z;
    logic       chk_co;
    int         lat;
    int         acc;
    int         id;
  } exp_t;

  exp_t q[$];

  ula_lo_seq #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .resu      (resu),
    .o         (o),
    .c         (c),
    .s         (s),
    .z         (z)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t%0d actual=%0h expected=%0h", nm, id, act, exp);
    end
  endtask

  function automatic int sh_lat(input int n);
`ifdef ULA_LO_SEQ_BARREL_EN
    return 1;
`else
    return 1 + n;
`endif
  endfunction

  // Drive one request, wait (bounded) for its accept edge, then queue the expectation
  task automatic issue(input int id, input logic [4:0] iop, input logic [7:0] ia, input logic [7:0] ib,
                       input logic [7:0] eres, input logic eo, input logic ec, input logic es,
                       input logic ez, input logic eco, input int elat);
    exp_t e;
    bit   acc;
    int   e_cyc;
    e.resu = eres; e.o = eo; e.c = ec; e.s = es; e.z = ez;
    e.chk_co = eco; e.lat = elat; e.id = id; e.acc = 0;
    in_valid = 1'b1; op = iop; a = ia; b = ib;
    acc = 1'b0;
    e_cyc = 0;
    for (int k = 0; k < 60 && !acc; k++) begin
      @(negedge clk);
      acc   = in_ready;
      e_cyc = cyc;
      @(posedge clk);
      #1;
    end
    if (acc) begin
      e.acc = e_cyc;
      q.push_back(e);
    end else begin
      chk("accept_timeout", id, 32'd0, 32'd1);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input int id);
    for (int k = 0; k < 100; k++) begin
      if (q.size() == 0) break;
      @(posedge clk);
      #1;
    end
    chk("drain", id, q.size(), 0);
  endtask

  // Monitor: compare every presented result against the head of the scoreboard
  bit seen = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      seen = 1'b0;
    end else if (out_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_output", 0, 32'd1, 32'd0);
      end else begin
        if (!seen) begin
          chk("latency", q[0].id, cyc - q[0].acc, q[0].lat);
          seen = 1'b1;
        end
        chk("resu", q[0].id, resu, q[0].resu);
        chk("s", q[0].id, s, q[0].s);
        chk("z", q[0].id, z, q[0].z);
        if (q[0].chk_co) begin
          chk("c", q[0].id, c, q[0].c);
          chk("o", q[0].id, o, q[0].o);
        end
        if (out_ready) begin
          void'(q.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state while held low
    #12;
    chk("rst_out_valid", 0, out_valid, 1'b0);
    chk("rst_in_ready", 0, in_ready, 1'b1);
    chk("rst_resu", 0, resu, 8'h00);
    chk("rst_flags", 0, {o, c, s, z}, 4'b0000);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_in_ready", 0, in_ready, 1'b1);
    chk("idle_out_valid", 0, out_valid, 1'b0);

    //     id  op        A      B      RESU   O     C     S     Z     CO    L
    issue(1,  5'b01000, 8'h81, 8'h03, 8'h08, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, sh_lat(3));
    issue(2,  5'b01001, 8'h90, 8'h02, 8'hE4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, sh_lat(2));
    issue(3,  5'b01100, 8'h01, 8'h01, 8'h80, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, sh_lat(1));
    issue(4,  5'b10110, 8'h5A, 8'h5A, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1);
    issue(5,  5'b10011, 8'h00, 8'h7F, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1);
    issue(6,  5'b01011, 8'h80, 8'h01, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, sh_lat(1));
    issue(7,  5'b01000, 8'h3C, 8'h08, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1);
    issue(8,  5'b01010, 8'hF0, 8'h07, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, sh_lat(7));
    issue(9,  5'b01100, 8'h01, 8'h01, 8'h80, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, sh_lat(1));
    issue(10, 5'b10000, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1);
    issue(11, 5'b11111, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1);
    issue(12, 5'b00101, 8'h12, 8'h34, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    issue(13, 5'b01000, 8'h40, 8'h01, 8'h80, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, sh_lat(1));
    drain(13);

    // Consumer stall: result held, requests ignored while not ready
    out_ready = 1'b0;
    issue(14, 5'b10001, 8'hF0, 8'h3C, 8'h30, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; op = 5'b11010; a = 8'h0F; b = 8'h00;
      @(negedge clk);
      chk("stall_in_ready", 14, in_ready, 1'b0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    issue(15, 5'b10111, 8'h81, 8'h02, 8'h83, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1);

    // Asynchronous reset in the middle of a 5-step shift
    issue(16, 5'b01000, 8'h01, 8'h05, 8'h20, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, sh_lat(5));
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    q.delete();
    chk("arst_out_valid", 16, out_valid, 1'b0);
    chk("arst_resu", 16, resu, 8'h00);
    chk("arst_flags", 16, {o, c, s, z}, 4'b0000);
    chk("arst_in_ready", 16, in_ready, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 16, in_ready, 1'b1);
    chk("post_rst_out_valid", 16, out_valid, 1'b0);
    @(posedge clk); #1;

    issue(17, 5'b11010, 8'h0F, 8'h00, 8'hF0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1);
    drain(17);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
